// File: rtl/seq_bus_pkg.sv
// -----------------------------------------------------------------------------
// seq_bus_pkg
// Shared definitions for the sequenced single-bus datapath: opcode values,
// control-step encodings and the ALU-op classifier.
// State codes are plain localparams on a 3-bit type so that legacy control
// logic can compare against them directly.
// -----------------------------------------------------------------------------
package seq_bus_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd5;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd6;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd7;
    localparam logic [OP_W-1:0] OP_HALT = 5'd31;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t T0   = 3'd1;
    localparam state_t T1   = 3'd2;
    localparam state_t T2   = 3'd3;
    localparam state_t T3   = 3'd4;
    localparam state_t T4   = 3'd5;
    localparam state_t T5   = 3'd6;
    localparam state_t HALT = 3'd7;

    // Opcodes 0..7 are the register-register ALU instructions.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/seq_bus_datapath_if.sv
// -----------------------------------------------------------------------------
// seq_bus_datapath_if
// Instruction-memory read handshake between the datapath (master) and the
// instruction memory (slave).
//   mem_req   : read request, held until acknowledged
//   mem_addr  : read address
//   mem_ack   : read data valid this cycle
//   mem_rdata : instruction word
// -----------------------------------------------------------------------------
interface seq_bus_datapath_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/seq_bus_alu.sv
// -----------------------------------------------------------------------------
// seq_bus_alu
// Purely combinational ALU for the datapath.
//   op_i     : opcode (only 0..7 are meaningful, others yield 0)
//   a_i      : first operand (Y register)
//   b_i      : second operand (R[rc]); low $clog2(DATA_W) bits give shift amount
//   result_o : result, truncated to DATA_W
// -----------------------------------------------------------------------------
module seq_bus_alu
    import seq_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        // NOTE: assigning a default before the case means no path leaves the
        // output unassigned, so no latch can be inferred.
        result_o = '0;
        case (op_i)
            OP_ADD: result_o = a_i + b_i;
            OP_SUB: result_o = a_i - b_i;
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_SHR: result_o = a_i >> shamt;
            OP_SHL: result_o = a_i << shamt;
            OP_NEG: result_o = '0 - a_i;
            OP_NOT: result_o = ~a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/seq_bus_datapath.sv
// -----------------------------------------------------------------------------
// seq_bus_datapath
// Single-bus CPU datapath (register file, PC, IR, MAR, MDR, Y, Z) with a
// built-in control-step sequencer: fetch T0-T2, execute T3-T5. Executes
// register-register ALU instructions autonomously.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous, active-high
//   run      : leave IDLE and start fetching
//   mem      : instruction-memory handshake (master side)
//   halted   : high while in HALT
//   illegal  : one-cycle pulse in T3 on an undefined opcode
//   pc_out   : current PC
//   dbg_sel  : debug register select
//   dbg_data : combinational R[dbg_sel]
//
// Build option
//   SEQ_BUS_DATAPATH_R0_ZERO_EN : R0 reads as zero and writes to R0 are dropped.
//
// Parameter constraint: DATA_W >= 5 + 3*REG_AW (opcode plus three index fields).
// -----------------------------------------------------------------------------
module seq_bus_datapath
    import seq_bus_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    seq_bus_datapath_if.master  mem,
    output logic                halted,
    output logic                illegal,
    output logic [DATA_W-1:0]   pc_out,
    input  logic [REG_AW-1:0]   dbg_sel,
    output logic [DATA_W-1:0]   dbg_data
);

`ifdef SEQ_BUS_DATAPATH_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam int FIELD_LSB = DATA_W - OP_W - 3 * REG_AW;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] y_q,   y_d;
    logic [DATA_W-1:0] z_q,   z_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Instruction fields: op, then ra, rb, rc packed directly below it.
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] ra, rb, rc;
    assign op = ir_q[DATA_W-1 -: OP_W];
    assign ra = ir_q[DATA_W-OP_W-1 -: REG_AW];
    assign rb = ir_q[DATA_W-OP_W-REG_AW-1 -: REG_AW];
    assign rc = ir_q[DATA_W-OP_W-2*REG_AW-1 -: REG_AW];

    generate
        if (FIELD_LSB > 0) begin : g_ir_pad
            logic unused_ir_pad;
            assign unused_ir_pad = ^ir_q[FIELD_LSB-1:0];
        end
    endgenerate

    // Register read ports; R0 is forced to zero when the option is built in.
    logic [DATA_W-1:0] rb_val, rc_val, alu_res;
    assign rb_val   = (R0_ZERO && rb == '0)      ? '0 : regs_q[rb];
    assign rc_val   = (R0_ZERO && rc == '0)      ? '0 : regs_q[rc];
    assign dbg_data = (R0_ZERO && dbg_sel == '0) ? '0 : regs_q[dbg_sel];

    seq_bus_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i    (op),
        .a_i     (y_q),
        .b_i     (rc_val),
        .result_o(alu_res)
    );

    assign mem.mem_req  = (state_q == T1);
    assign mem.mem_addr = mar_q;
    assign halted       = (state_q == HALT);
    assign illegal      = (state_q == T3) && !is_alu_op(op) && (op != OP_HALT);
    assign pc_out       = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            IDLE: if (run) state_d = T0;
            T0: begin
                mar_d   = pc_q;
                z_d     = pc_q + DATA_W'(1);
                state_d = T1;
            end
            // Wait states: hold here until the memory acknowledges.
            T1: if (mem.mem_ack) begin
                mdr_d   = mem.mem_rdata;
                pc_d    = z_q;
                state_d = T2;
            end
            T2: begin
                ir_d    = mdr_q;
                state_d = T3;
            end
            T3: begin
                if (is_alu_op(op)) begin
                    y_d     = rb_val;
                    state_d = T4;
                end else if (op == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = T0;
                end
            end
            T4: begin
                z_d     = alu_res;
                state_d = T5;
            end
            T5:      state_d = T0;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    // Register file write happens in T5; writes to R0 vanish when R0 is hardwired.
    logic wr_en;
    assign wr_en = (state_q == T5) && !(R0_ZERO && ra == '0);

    // NOTE: the register file is architecturally visible after reset, so it
    // is cleared like any other register rather than left as an unreset RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[ra] <= z_q;
        end
    end

endmodule

// File: tb/tb_seq_bus_datapath.sv
// -----------------------------------------------------------------------------
// tb_seq_bus_datapath
// Self-checking bench for seq_bus_datapath (DATA_W=32, NUM_REGS=16). Plays the
// instruction memory, keeps an instruction-level reference model (register
// array + PC) and checks outputs on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_bus_datapath;
    import seq_bus_pkg::*;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

`ifdef SEQ_BUS_DATAPATH_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              halted, illegal;
    logic [DATA_W-1:0] pc_out, dbg_data;
    logic [3:0]        dbg_sel = '0;

    seq_bus_datapath_if #(.DATA_W(DATA_W)) bus ();

    seq_bus_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .mem     (bus.master),
        .halted  (halted),
        .illegal (illegal),
        .pc_out  (pc_out),
        .dbg_sel (dbg_sel),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [DATA_W-1:0] m_pc;
    bit                have_prev = 0;
    int                prev_cyc  = 0;
    int                prev_lat  = 0;

    function automatic logic [DATA_W-1:0] m_rd(input int idx);
        if (R0Z && idx == 0) return '0;
        return m_regs[idx];
    endfunction

    function automatic logic [DATA_W-1:0] alu_ref(input int op, input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        int sh;
        sh = int'(b % DATA_W);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a >> sh;
            5: return a << sh;
            6: return 0 - a;
            default: return ~a;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_pc      = '0;
        have_prev = 0;
    endtask

    task automatic dump_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            dbg_sel = 4'(i);
            #1;
            n_cmp++;
            if (dbg_data !== m_rd(i)) begin
                n_bad++;
                $display("FAIL %s R%0d: got %h expected %h", tag, i, dbg_data, m_rd(i));
            end
        end
    endtask

    // Serves one instruction fetch (with the given wait states) and follows it
    // through execution, checking handshake, PC, timing and the result.
    task automatic exec(input int op, input int ra, input int rb, input int rc, input int waits);
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] res;
        int t;
        word = {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
        t = 0;
        while (bus.mem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_timeout: mem_req=%b expected 1 within 50 cycles", bus.mem_req);
            return;
        end
        if (have_prev) begin
            n_cmp++;
            if (cyc - prev_cyc !== prev_lat) begin
                n_bad++;
                $display("FAIL latency: got %0d cycles expected %0d", cyc - prev_cyc, prev_lat);
            end
        end
        prev_cyc = cyc;
        n_cmp++;
        if (bus.mem_addr !== m_pc) begin
            n_bad++;
            $display("FAIL mem_addr: got %h expected %h", bus.mem_addr, m_pc);
        end
        for (int w = 0; w < waits; w++) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'($urandom);
            @(negedge clk);
            n_cmp++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== m_pc || pc_out !== m_pc) begin
                n_bad++;
                $display("FAIL wait_hold: req=%b addr=%h pc=%h expected req=1 addr=pc=%h",
                         bus.mem_req, bus.mem_addr, pc_out, m_pc);
            end
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = word;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'($urandom);
        m_pc = m_pc + 1;
        n_cmp++;
        if (pc_out !== m_pc || bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL after_ack: pc=%h req=%b expected pc=%h req=0", pc_out, bus.mem_req, m_pc);
        end
        @(negedge clk);  // decode step
        if (op <= 7) begin
            n_cmp++;
            if (illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_alu: got %b expected 0", illegal);
            end
            res = alu_ref(op, m_rd(rb), m_rd(rc));
            if (!(R0Z && ra == 0)) m_regs[ra] = res;
            dbg_sel = 4'(ra);
            repeat (3) @(negedge clk);
            n_cmp++;
            if (dbg_data !== m_rd(ra)) begin
                n_bad++;
                $display("FAIL result op%0d R%0d: got %h expected %h", op, ra, dbg_data, m_rd(ra));
            end
            have_prev = 1;
            prev_lat  = 6 + waits;
        end else if (op == 31) begin
            @(negedge clk);
            n_cmp++;
            if (halted !== 1'b1) begin
                n_bad++;
                $display("FAIL halt_enter: halted=%b expected 1", halted);
            end
            have_prev = 0;
        end else begin
            n_cmp++;
            if (illegal !== 1'b1) begin
                n_bad++;
                $display("FAIL illegal_pulse: got %b expected 1", illegal);
            end
            @(negedge clk);
            n_cmp++;
            if (illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_width: got %b expected 0", illegal);
            end
            dbg_sel = 4'(ra);
            #1;
            n_cmp++;
            if (dbg_data !== m_rd(ra)) begin
                n_bad++;
                $display("FAIL illegal_noreg R%0d: got %h expected %h", ra, dbg_data, m_rd(ra));
            end
            have_prev = 1;
            prev_lat  = 4 + waits;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.mem_req !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0 || pc_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: req=%b halted=%b illegal=%b pc=%h expected 0,0,0,0",
                     bus.mem_req, halted, illegal, pc_out);
        end
        dump_regs("reset_regs");
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.mem_req !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_hold: mem_req=%b expected 0", bus.mem_req);
            end
        end
    endtask

    task automatic test_fetch_timing();
        run = 1'b1;
        exec(OP_NOT, 1, 0, 0, 0);     // R1 = ~0; checks PC 0->1, single-cycle req
        run = 1'b0;                   // no effect once running
    endtask

    task automatic test_add_sub();
        exec(OP_NEG, 4, 1, 0, 0);     // R4 = 1
        exec(OP_ADD, 5, 4, 4, 0);     // R5 = 2
        exec(OP_ADD, 6, 5, 4, 0);     // R6 = 3
        exec(OP_SHL, 2, 4, 6, 0);     // R2 = 8
        exec(OP_SUB, 2, 2, 4, 0);     // R2 = 7
        exec(OP_SUB, 3, 2, 5, 0);     // R3 = 5
        exec(OP_ADD, 1, 2, 3, 0);
        n_cmp++;
        if (dbg_data !== 32'd12) begin
            n_bad++;
            $display("FAIL add_7_5: got %h expected %h", dbg_data, 32'd12);
        end
        exec(OP_SUB, 1, 2, 3, 0);
        n_cmp++;
        if (dbg_data !== 32'd2) begin
            n_bad++;
            $display("FAIL sub_7_5: got %h expected %h", dbg_data, 32'd2);
        end
    endtask

    task automatic test_wait_states();
        exec(OP_OR, 13, 2, 3, 3);     // three wait states
        exec(OP_AND, 14, 2, 3, 1);    // also checks the 9-cycle latency above
    endtask

    task automatic test_shift_neg();
        exec(OP_SHL, 8, 4, 3, 0);     // R8 = 32
        exec(OP_ADD, 8, 8, 4, 0);     // R8 = 33
        exec(OP_SHL, 9, 4, 8, 0);
        n_cmp++;
        if (dbg_data !== 32'd2) begin
            n_bad++;
            $display("FAIL shl_by_33: got %h expected %h", dbg_data, 32'd2);
        end
        exec(OP_NEG, 10, 4, 0, 2);
        n_cmp++;
        if (dbg_data !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL neg_1: got %h expected %h", dbg_data, 32'hFFFF_FFFF);
        end
        exec(OP_SHR, 12, 10, 8, 0);   // all-ones >> 1
    endtask

    task automatic test_same_reg();
        exec(OP_ADD, 5, 5, 5, 0);
        n_cmp++;
        if (dbg_data !== 32'd4) begin
            n_bad++;
            $display("FAIL same_reg_add: got %h expected %h", dbg_data, 32'd4);
        end
    endtask

    task automatic test_r0();
        logic [DATA_W-1:0] exp0, exp11;
        exp0  = R0Z ? 32'd0 : 32'd12;
        exp11 = R0Z ? 32'd1 : 32'd13;
        exec(OP_ADD, 0, 2, 3, 0);
        n_cmp++;
        if (dbg_data !== exp0) begin
            n_bad++;
            $display("FAIL r0_write: got %h expected %h", dbg_data, exp0);
        end
        exec(OP_ADD, 11, 0, 4, 0);
        n_cmp++;
        if (dbg_data !== exp11) begin
            n_bad++;
            $display("FAIL r0_read: got %h expected %h", dbg_data, exp11);
        end
    endtask

    task automatic test_illegal();
        exec(12, 7, 1, 2, 0);
        exec(OP_ADD, 7, 4, 4, 0);     // next fetch must be at PC+1, 4-cycle gap
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            exec($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 2));
    endtask

    task automatic test_halt();
        exec(OP_HALT, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            run = k[0];
            @(negedge clk);
            n_cmp++;
            if (halted !== 1'b1 || bus.mem_req !== 1'b0 || pc_out !== m_pc) begin
                n_bad++;
                $display("FAIL halt_hold: halted=%b req=%b pc=%h expected 1,0,%h",
                         halted, bus.mem_req, pc_out, m_pc);
            end
        end
        dump_regs("halt_regs");
    endtask

    task automatic test_reset_mid_handshake();
        int t;
        do_reset();
        run = 1'b1;
        exec(OP_NOT, 6, 0, 0, 0);
        t = 0;
        while (bus.mem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_fetch_timeout: mem_req=%b expected 1", bus.mem_req);
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        reset         = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {5'(OP_ADD), 4'd1, 4'd6, 4'd6, 15'd0};
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b0 || pc_out !== '0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: req=%b pc=%h halted=%b expected 0,0,0",
                     bus.mem_req, pc_out, halted);
        end
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        run         = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_pc      = '0;
        have_prev = 0;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_idle: mem_req=%b expected 0", bus.mem_req);
        end
        dump_regs("mid_reset_regs");
        run = 1'b1;
        exec(OP_NOT, 3, 0, 0, 0);     // restarts fetching at address 0
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_fetch_timing();
        test_add_sub();
        test_wait_states();
        test_shift_neg();
        test_same_reg();
        test_r0();
        test_illegal();
        test_random();
        test_halt();
        test_reset_mid_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_bus_datapath.md
Name: seq_bus_datapath

Overview:
- Parametrised successor to the single-bus CPU datapath: general register file, PC/IR/MAR/MDR/Y/Z on one internal bus.
- Adds a built-in control-step sequencer (fetch T0–T2, execute T3–T5) and a req/ack instruction-memory handshake with wait states.
- Runs register-register ALU instructions autonomously.
- Sits between instruction memory and the future top-level CPU control unit.

Parameters:
- DATA_W, 32, width of the bus and of every register.
- NUM_REGS, 16, general registers; power of 2, 2..16.
- REG_AW, $clog2(NUM_REGS), width of a register index field (derived).
- Constraint: DATA_W >= 5 + 3*REG_AW.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- run  in  1  start execution from IDLE
- mem_req  out  1  instruction read request
- mem_addr  out  DATA_W  read address (= MAR)
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  instruction word
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on undefined opcode
- pc_out  out  DATA_W  current PC
- dbg_sel  in  REG_AW  debug register select
- dbg_data  out  DATA_W  combinational R[dbg_sel]

Behaviour:
- Reset: one clock, synchronous, active-high (clk, reset). All registers, PC, IR, MAR, MDR, Y, Z = 0; state IDLE; mem_req=0, halted=0, illegal=0. Reset applies mid-instruction and mid-handshake: mem_req drops the next cycle and the pending ack is discarded.
- IR fields: op=IR[DATA_W-1 -: 5]; ra, rb, rc are consecutive REG_AW fields below op, in that order.
- IDLE: run=1 -> T0; otherwise stay.
- T0: MAR<=PC; Z<=PC+1 (mod 2^DATA_W) -> T1.
- T1: mem_req=1, mem_addr=MAR. Hold until mem_ack=1. On ack: MDR<=mem_rdata, PC<=Z -> T2. Unbounded wait states allowed. mem_ack outside T1 is ignored.
- T2: IR<=MDR -> T3.
- T3: decode.
  - op 0..7: Y<=R[rb] -> T4.
  - op 31: -> HALT.
  - any other op: illegal=1 for this cycle -> T0.
- T4: Z<=ALU(op, Y, R[rc]) -> T5.
- ALU ops:
  - 0 add, 1 sub (Y-R[rc]), 2 and, 3 or.
  - 4 logical shr, 5 shl; shift amount = R[rc][$clog2(DATA_W)-1:0].
  - 6 neg (two's complement of Y), 7 not Y.
  - Results are truncated to DATA_W.
- T5: R[ra]<=Z -> T0.
- Instruction latency is 6 cycles plus wait states.
- HALT: halted=1; remains until reset; run is ignored.
- ra==rb==rc is legal: operands are latched in T3/T4 before the T5 write.
- PC wraps from all-ones to 0.

Optional Feature:
- Macro: SEQ_BUS_DATAPATH_R0_ZERO_EN.
- Defined: R0 reads as 0 on the bus and on dbg_data; T5 writes with ra=0 are dropped.
- Undefined: R0 is an ordinary general register.

Decomposition:
- Shared package seq_bus_pkg:
  - opcode constants OP_ADD..OP_NOT, OP_HALT=5'd31
  - state enum IDLE, T0, T1, T2, T3, T4, T5, HALT
- Sub-module: seq_bus_alu, combinational (op, a, b) -> result, parametrised on DATA_W.

Test Plan:
- Reset then run with mem_ack tied high: PC goes 0->1, IR loaded in T2, mem_req high for exactly one cycle, 6 cycles per instruction.
- Preload R2=7, R3=5 (ADD then SUB program); instruction ADD ra=1, rb=2, rc=3 -> R1=12 at T5 (dbg_sel=1 reads 12); SUB gives R1=2.
- mem_ack delayed 3 cycles -> state stays T1, mem_req held, mem_addr stable, PC unchanged until ack.
- SHL with R[rc]=33, DATA_W=32 -> shift by 1; NEG of 1 -> 32'hFFFF_FFFF; op 12 -> illegal pulse one cycle, no register change, next fetch at PC+1.
- Op 31 -> halted=1 held; run toggling has no effect; reset asserted during T1 -> mem_req=0 next cycle, all registers 0, state IDLE.
- With SEQ_BUS_DATAPATH_R0_ZERO_EN: ADD ra=0 -> R0 stays 0, and an instruction reading R0 sees 0.
